// File: rtl/usp_ev_reg_responder.sv
// rtl/usp_ev_reg_responder.sv - USP-side EV registration responder (M1 in, M2 out)
//
// Accepts one encrypted M1 beat with the claimed EV identity, decrypts it with
// the USP key, checks PSIDEVi against H4({IDi, RSi, 0}), then computes
// Aj = H4({IDi, CHi, RSi, USP_ID}) and returns M2 = {USP_ID, Aj} ^ {2{IDi}}.
// A failed identity check returns a reject (m2_ok=0, m2_data=0).
// H4 runs one round per clock.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   m1_valid/m1_ready   request handshake
//   m1_data[191:0]      {PSIDEVi, CHi, RSi} ^ {3{key}}
//   ev_id_i[63:0]       claimed EV identity, sampled with m1_data
//   usp_key_j[63:0]     USP key, sampled at accept
//   m2_valid/m2_ready   response handshake
//   m2_data[127:0]      encrypted response, 0 on reject or when m2_valid=0
//   m2_ok               1 = accepted, 0 = rejected
//   busy                high whenever not IDLE
//   acc_count/rej_count saturating accept/reject counters
module usp_ev_reg_responder #(
  parameter logic [63:0] USP_ID = 64'hABCDEF9876543210,
  parameter int          CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m1_valid,
  output logic             m1_ready,
  input  logic [191:0]     m1_data,
  input  logic [63:0]      ev_id_i,
  input  logic [63:0]      usp_key_j,
  output logic             m2_valid,
  input  logic             m2_ready,
  output logic [127:0]     m2_data,
  output logic             m2_ok,
  output logic             busy,
  output logic [CNT_W-1:0] acc_count,
  output logic [CNT_W-1:0] rej_count
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HASH_PS = 2'd1,
    ST_HASH_AJ = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  localparam logic [63:0]      HASH_IV  = 64'hA5A5A5A5A5A5A5A5;
  localparam logic [63:0]      HASH_K   = 64'hC3C3C3C3C3C3C3C3;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [63:0]      psidev_q, psidev_d;
  logic [63:0]      ch_q, ch_d;
  logic [63:0]      rs_q, rs_d;
  logic [63:0]      ev_id_q, ev_id_d;
  logic [63:0]      s_q, s_d;
  logic [1:0]       round_q, round_d;
  logic [127:0]     m2_data_q, m2_data_d;
  logic             m2_ok_q, m2_ok_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] rej_q, rej_d;

  logic [63:0]      hash_word;
  logic [63:0]      hash_mix;
  logic [63:0]      round_out;

  // Message word for the current round: word i is d[64i+63:64i].
  // PSIDEV check hashes {IDi, RSi, 128'd0}; Aj hashes {IDi, CHi, RSi, USP_ID}.
  always_comb begin
    hash_word = 64'd0;
    if (state_q == ST_HASH_PS) begin
      case (round_q)
        2'd0:    hash_word = 64'd0;
        2'd1:    hash_word = 64'd0;
        2'd2:    hash_word = rs_q;
        default: hash_word = ev_id_q;
      endcase
    end else if (state_q == ST_HASH_AJ) begin
      case (round_q)
        2'd0:    hash_word = USP_ID;
        2'd1:    hash_word = rs_q;
        2'd2:    hash_word = ch_q;
        default: hash_word = ev_id_q;
      endcase
    end
  end

  // One H4 round; the round constant is HASH_K shifted right by 8*round.
  always_comb begin
    hash_mix  = s_q ^ hash_word;
    round_out = (hash_mix << 3) ^ (hash_mix >> 5) ^ (HASH_K >> {round_q, 3'b000});
  end

  always_comb begin
    state_d   = state_q;
    psidev_d  = psidev_q;
    ch_d      = ch_q;
    rs_d      = rs_q;
    ev_id_d   = ev_id_q;
    s_d       = s_q;
    round_d   = round_q;
    m2_data_d = m2_data_q;
    m2_ok_d   = m2_ok_q;
    acc_d     = acc_q;
    rej_d     = rej_q;

    case (state_q)
      ST_IDLE: begin
        if (m1_valid) begin
          {psidev_d, ch_d, rs_d} = m1_data ^ {3{usp_key_j}};
          ev_id_d = ev_id_i;
          s_d     = HASH_IV;
          round_d = 2'd0;
          state_d = ST_HASH_PS;
        end
      end

      ST_HASH_PS: begin
        s_d     = round_out;
        round_d = round_q + 2'd1;
        if (round_q == 2'd3) begin
          // Compare the unregistered final round so a mismatch reaches RESP
          // without an extra cycle.
          if (round_out == psidev_q) begin
            s_d     = HASH_IV;
            round_d = 2'd0;
            state_d = ST_HASH_AJ;
          end else begin
            m2_ok_d   = 1'b0;
            m2_data_d = 128'd0;
            state_d   = ST_RESP;
          end
        end
      end

      ST_HASH_AJ: begin
        s_d     = round_out;
        round_d = round_q + 2'd1;
        if (round_q == 2'd3) begin
          m2_ok_d   = 1'b1;
          m2_data_d = {USP_ID, round_out} ^ {2{ev_id_q}};
          state_d   = ST_RESP;
        end
      end

      default: begin
        if (m2_ready) begin
          // Count on the handshake so an aborted response is never counted.
          if (m2_ok_q) begin
            if (acc_q != CNT_MAX) acc_d = acc_q + CNT_ONE;
          end else begin
            if (rej_q != CNT_MAX) rej_d = rej_q + CNT_ONE;
          end
          m2_data_d = 128'd0;
          m2_ok_d   = 1'b0;
          state_d   = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      psidev_q  <= 64'd0;
      ch_q      <= 64'd0;
      rs_q      <= 64'd0;
      ev_id_q   <= 64'd0;
      s_q       <= 64'd0;
      round_q   <= 2'd0;
      m2_data_q <= 128'd0;
      m2_ok_q   <= 1'b0;
      acc_q     <= '0;
      rej_q     <= '0;
    end else begin
      state_q   <= state_d;
      psidev_q  <= psidev_d;
      ch_q      <= ch_d;
      rs_q      <= rs_d;
      ev_id_q   <= ev_id_d;
      s_q       <= s_d;
      round_q   <= round_d;
      m2_data_q <= m2_data_d;
      m2_ok_q   <= m2_ok_d;
      acc_q     <= acc_d;
      rej_q     <= rej_d;
    end
  end

  assign m1_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign m2_valid  = (state_q == ST_RESP);
  // m2_data_q is only non-zero in RESP, so this gating is belt-and-braces.
  assign m2_data   = m2_valid ? m2_data_q : 128'd0;
  assign m2_ok     = m2_ok_q;
  assign acc_count = acc_q;
  assign rej_count = rej_q;

endmodule

// File: tb/tb_usp_ev_reg_responder.sv
// tb/tb_usp_ev_reg_responder.sv - directed self-checking bench for usp_ev_reg_responder
module tb_usp_ev_reg_responder;

  localparam logic [63:0] USP_ID = 64'hABCDEF9876543210;
  localparam logic [63:0] EV_ID  = 64'h0000_0000_0000_00E1;
  localparam logic [63:0] CH     = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] RS     = 64'h5A5A_1234_DEAD_BEEF;
  localparam logic [63:0] KEY    = 64'h0F0F0F0F0F0F0F0F;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         m1_valid = 1'b0;
  logic [191:0] m1_data = '0;
  logic [63:0]  ev_id_i = '0;
  logic [63:0]  usp_key_j = '0;
  logic         m2_ready = 1'b0;

  logic         m1_ready, m2_valid, m2_ok, busy;
  logic [127:0] m2_data;
  logic [15:0]  acc_count, rej_count;

  logic         s_m1_ready, s_m2_valid, s_m2_ok, s_busy;
  logic [127:0] s_m2_data;
  logic [1:0]   s_acc_count, s_rej_count;

  int checks = 0;
  int errors = 0;

  usp_ev_reg_responder #(.USP_ID(USP_ID), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_data(m1_data),
    .ev_id_i(ev_id_i), .usp_key_j(usp_key_j),
    .m2_valid(m2_valid), .m2_ready(m2_ready), .m2_data(m2_data), .m2_ok(m2_ok),
    .busy(busy), .acc_count(acc_count), .rej_count(rej_count)
  );

  usp_ev_reg_responder #(.USP_ID(USP_ID), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst),
    .m1_valid(m1_valid), .m1_ready(s_m1_ready), .m1_data(m1_data),
    .ev_id_i(ev_id_i), .usp_key_j(usp_key_j),
    .m2_valid(s_m2_valid), .m2_ready(m2_ready), .m2_data(s_m2_data), .m2_ok(s_m2_ok),
    .busy(s_busy), .acc_count(s_acc_count), .rej_count(s_rej_count)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] h4(input logic [255:0] d);
    logic [63:0] s;
    logic [63:0] k;
    s = 64'hA5A5A5A5A5A5A5A5;
    for (int i = 0; i < 4; i++) begin
      k = 64'hC3C3C3C3C3C3C3C3 >> (8 * i);
      s = s ^ d[64*i +: 64];
      s = (s << 3) ^ (s >> 5) ^ k;
    end
    return s;
  endfunction

  function automatic logic [127:0] exp_m2(input logic [63:0] id, input logic [63:0] ch,
                                          input logic [63:0] rs);
    logic [63:0] aj;
    aj = h4({id, ch, rs, USP_ID});
    return {USP_ID, aj} ^ {id, id};
  endfunction

  function automatic logic [191:0] make_m1(input logic [63:0] id, input logic [63:0] ch,
                                           input logic [63:0] rs, input logic [63:0] key,
                                           input logic flip);
    logic [63:0] ps;
    ps = h4({id, rs, 128'd0});
    ps[0] = ps[0] ^ flip;
    return {ps, ch, rs} ^ {key, key, key};
  endfunction

  task automatic do_reset();
    m1_valid = 1'b0;
    m2_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Presents one beat at a negedge; returns just after the accept edge (cycle T+1).
  task automatic send_m1(input logic [191:0] d, input logic [63:0] id, input logic [63:0] key);
    @(negedge clk);
    m1_valid  = 1'b1;
    m1_data   = d;
    ev_id_i   = id;
    usp_key_j = key;
    @(posedge clk);
    #1;
    m1_valid  = 1'b0;
  endtask

  // Returns at the negedge of the first m2_valid cycle; lat counts cycles from T.
  task automatic wait_valid(output int lat);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (m2_valid) return;
    end
    lat = -1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (m1_ready !== 1'b1) begin errors++; $display("FAIL reset_m1_ready: got %b want 1", m1_ready); end
    checks++; if (m2_valid !== 1'b0) begin errors++; $display("FAIL reset_m2_valid: got %b want 0", m2_valid); end
    checks++; if (m2_data !== 128'd0) begin errors++; $display("FAIL reset_m2_data: got %h want 0", m2_data); end
    checks++; if (m2_ok !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_ok_busy: got %b%b want 00", m2_ok, busy); end
    checks++; if (acc_count !== 16'd0 || rej_count !== 16'd0) begin errors++; $display("FAIL reset_counts: got %0d/%0d want 0/0", acc_count, rej_count); end
  endtask

  task automatic test_valid();
    int lat;
    logic [127:0] exp;
    exp = exp_m2(EV_ID, CH, RS);
    do_reset();
    m2_ready = 1'b1;
    send_m1(make_m1(EV_ID, CH, RS, KEY, 1'b0), EV_ID, KEY);
    wait_valid(lat);
    checks++; if (lat !== 9) begin errors++; $display("FAIL valid_latency: got %0d want 9", lat); end
    checks++; if (m2_ok !== 1'b1) begin errors++; $display("FAIL valid_ok: got %b want 1", m2_ok); end
    checks++; if (m2_data !== exp) begin errors++; $display("FAIL valid_data: got %h want %h", m2_data, exp); end
    checks++; if ((m2_data[127:64] ^ EV_ID) !== USP_ID) begin errors++; $display("FAIL valid_usp_id: got %h want %h", m2_data[127:64] ^ EV_ID, USP_ID); end
    @(negedge clk);
    checks++; if (m2_valid !== 1'b0 || m1_ready !== 1'b1) begin errors++; $display("FAIL valid_one_cycle: got valid=%b ready=%b want 0 1", m2_valid, m1_ready); end
    checks++; if (m2_data !== 128'd0) begin errors++; $display("FAIL valid_data_idle: got %h want 0", m2_data); end
    checks++; if (acc_count !== 16'd1 || rej_count !== 16'd0) begin errors++; $display("FAIL valid_counts: got %0d/%0d want 1/0", acc_count, rej_count); end
  endtask

  task automatic test_reject();
    int lat;
    do_reset();
    m2_ready = 1'b1;
    send_m1(make_m1(EV_ID, CH, RS, KEY, 1'b1), EV_ID, KEY);
    wait_valid(lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL reject_latency: got %0d want 5", lat); end
    checks++; if (m2_ok !== 1'b0) begin errors++; $display("FAIL reject_ok: got %b want 0", m2_ok); end
    checks++; if (m2_data !== 128'd0) begin errors++; $display("FAIL reject_data: got %h want 0", m2_data); end
    @(negedge clk);
    checks++; if (rej_count !== 16'd1 || acc_count !== 16'd0) begin errors++; $display("FAIL reject_counts: got acc=%0d rej=%0d want 0 1", acc_count, rej_count); end
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    logic [127:0] exp;
    exp = exp_m2(EV_ID, CH, RS);
    do_reset();
    m2_ready = 1'b0;
    send_m1(make_m1(EV_ID, CH, RS, KEY, 1'b0), EV_ID, KEY);
    wait_valid(lat);
    checks++; if (lat !== 9) begin errors++; $display("FAIL bp_latency: got %0d want 9", lat); end
    bad = 0;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      if (m2_valid !== 1'b1 || m2_data !== exp || m2_ok !== 1'b1 || m1_ready !== 1'b0 || acc_count !== 16'd0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold: got %0d bad cycles want 0", bad); end
    @(negedge clk);
    checks++; if (m2_valid !== 1'b1 || m2_data !== exp) begin errors++; $display("FAIL bp_cycle8: got valid=%b data=%h want 1 %h", m2_valid, m2_data, exp); end
    m2_ready = 1'b1;
    @(negedge clk);
    checks++; if (m1_ready !== 1'b1 || m2_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got ready=%b valid=%b want 1 0", m1_ready, m2_valid); end
    @(negedge clk);
    checks++; if (acc_count !== 16'd1) begin errors++; $display("FAIL bp_count: got %0d want 1", acc_count); end
  endtask

  task automatic test_busy_ignore();
    int lat;
    logic [127:0] exp;
    exp = exp_m2(EV_ID, CH, RS);
    do_reset();
    m2_ready = 1'b1;
    send_m1(make_m1(EV_ID, CH, RS, KEY, 1'b0), EV_ID, KEY);
    @(negedge clk);
    @(negedge clk);
    m1_valid  = 1'b1;
    m1_data   = make_m1(64'h77, 64'h99, 64'h55, 64'h3C3C, 1'b0);
    ev_id_i   = 64'h77;
    usp_key_j = 64'h3C3C;
    checks++; if (m1_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL busy_ready: got ready=%b busy=%b want 0 1", m1_ready, busy); end
    @(negedge clk);
    m1_valid = 1'b0;
    wait_valid(lat);
    checks++; if (lat + 3 !== 9) begin errors++; $display("FAIL busy_latency: got %0d want 9", lat + 3); end
    checks++; if (m2_data !== exp || m2_ok !== 1'b1) begin errors++; $display("FAIL busy_data: got %h ok=%b want %h 1", m2_data, m2_ok, exp); end
    @(negedge clk);
    checks++; if (acc_count !== 16'd1 || m1_ready !== 1'b1) begin errors++; $display("FAIL busy_count: got %0d ready=%b want 1 1", acc_count, m1_ready); end
  endtask

  task automatic test_mid_reset();
    int lat;
    int seen;
    do_reset();
    m2_ready = 1'b1;
    send_m1(make_m1(EV_ID, CH, RS, KEY, 1'b0), EV_ID, KEY);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (m1_ready !== 1'b1 || busy !== 1'b0 || m2_valid !== 1'b0 || m2_data !== 128'd0 || m2_ok !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs: got ready=%b busy=%b valid=%b ok=%b want 1 0 0 0", m1_ready, busy, m2_valid, m2_ok);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (m2_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_valid: got %0d valid cycles want 0", seen); end
    checks++; if (acc_count !== 16'd0 || rej_count !== 16'd0) begin errors++; $display("FAIL midrst_counts: got %0d/%0d want 0/0", acc_count, rej_count); end
    send_m1(make_m1(EV_ID, CH, RS, KEY, 1'b0), EV_ID, KEY);
    wait_valid(lat);
    checks++; if (lat !== 9 || m2_data !== exp_m2(EV_ID, CH, RS)) begin errors++; $display("FAIL midrst_fresh: got lat=%0d data=%h want 9", lat, m2_data); end
    @(negedge clk);
    checks++; if (acc_count !== 16'd1) begin errors++; $display("FAIL midrst_fresh_count: got %0d want 1", acc_count); end
  endtask

  task automatic test_saturation();
    int lat;
    logic [1:0] exp_s;
    logic [63:0] id;
    do_reset();
    m2_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      id = 64'h100 + 64'(k);
      send_m1(make_m1(id, CH ^ 64'(k), RS, KEY, 1'b0), id, KEY);
      wait_valid(lat);
      checks++; if (lat !== 9 || m2_data !== exp_m2(id, CH ^ 64'(k), RS)) begin errors++; $display("FAIL sat_resp%0d: got lat=%0d data=%h", k, lat, m2_data); end
      @(negedge clk);
      exp_s = (k < 3) ? 2'(k + 1) : 2'd3;
      checks++; if (s_acc_count !== exp_s) begin errors++; $display("FAIL sat_small%0d: got %0d want %0d", k, s_acc_count, exp_s); end
      checks++; if (acc_count !== 16'(k + 1)) begin errors++; $display("FAIL sat_wide%0d: got %0d want %0d", k, acc_count, k + 1); end
    end
  endtask

  initial begin
    test_reset();
    test_valid();
    test_reject();
    test_backpressure();
    test_busy_ignore();
    test_mid_reset();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
